if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction fetch stage of the pipeline, directly upstream of the ID-stage register file and decoder. It owns the fetch PC, issues single-outstanding word reads to instruction memory, and presents each fetched instruction with its PC to ID through a valid/ready handshake. It also applies control-flow redirects from later stages, discarding any in-flight or held instruction on the wrong path.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset; bits [1:0] must be 0.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  memory read request; held high until mem_ack.
- mem_addr  out  32  word-aligned fetch address; stable while mem_req high.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored, treated as 00.
- id_valid  out  1  id_inst/id_pc hold a valid instruction for ID.
- id_ready  in  1  ID accepts the instruction this cycle.
- id_pc  out  32  PC of id_inst.
- id_inst  out  32  fetched instruction.

## Operation
- States: IDLE, FETCH, DRAIN, HOLD. mem_req = (FETCH or DRAIN); id_valid = HOLD. All outputs are registered or decoded from the state register only.
- Registers: mem_addr (current request address), pend_pc (redirect target held in DRAIN), id_pc, id_inst.
- IDLE: next edge -> FETCH, mem_addr = RESET_PC.
- FETCH, mem_ack=1, redirect_valid=0: id_inst <= mem_rdata, id_pc <= mem_addr -> HOLD.
- FETCH, mem_ack=1, redirect_valid=1: discard rdata, mem_addr <= redirect_pc -> FETCH. A new request starts next cycle.
- FETCH, mem_ack=0, redirect_valid=1: pend_pc <= redirect_pc -> DRAIN. The request already issued cannot be withdrawn, so mem_addr is unchanged.
- DRAIN, mem_ack=0: stay. A further redirect overwrites pend_pc; the latest redirect wins.
- DRAIN, mem_ack=1: discard rdata, mem_addr <= (redirect_valid ? redirect_pc : pend_pc) -> FETCH.
- HOLD, redirect_valid=1: drop the held instruction, mem_addr <= redirect_pc -> FETCH. Redirect has priority over id_ready. A simultaneous id_valid&id_ready is not a transfer, and ID must discard it.
- HOLD, id_ready=1 (no redirect): transfer complete, mem_addr <= id_pc + 4 -> FETCH.
- HOLD, id_ready=0: stay. id_pc and id_inst are held stable (stall).
- mem_ack in IDLE or HOLD is a protocol error and is ignored.
- Address arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. mem_addr[1:0] is always 00.

## Timing
- Reset values (asserted asynchronously on rst rising): state IDLE, mem_req 0, mem_addr RESET_PC, pend_pc 0, id_valid 0, id_pc 0, id_inst 32'h0000_0013 (NOP).
- Reset mid-operation aborts everything immediately, including any outstanding request. Memory is reset by the same rst.
- First request: mem_req rises on the first clock edge after rst deasserts.
- Latency: with ack in cycle N, id_valid is high from cycle N+1.
- Zero-wait memory (ack in the first mem_req cycle) with id_ready held 1 gives 1 instruction per 2 cycles.
- After a redirect in FETCH without ack, the first redirected request starts the cycle after the stale ack.
- mem_req falls in the cycle after ack only when moving to HOLD. Otherwise it stays high, and mem_addr changes at that edge.

## Test plan
- Reset, zero-wait memory, id_ready=1, mem_rdata = address: id_pc sequence 0,4,8,12 with id_inst equal to id_pc, id_valid high every other cycle.
- ID stall: hold id_ready=0 for 5 cycles in HOLD at PC 8 -> id_valid, id_pc=8 and id_inst stable, mem_req=0 throughout; release -> next mem_addr=12.
- 3-wait memory, redirect to 0x100 in the second wait cycle -> DRAIN, mem_addr stays 0x4 until ack. The stale word never reaches ID; the next request is 0x100 and id_pc=0x100.
- Two redirects during DRAIN (0x200 then 0x300) -> next fetch at 0x300 only. Redirect coincident with ack in FETCH -> rdata discarded, next mem_addr = target.
- Redirect coincident with id_ready in HOLD -> no transfer, next mem_addr = target. Redirect to 0x103 -> fetch 0x100. RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0.
- Assert rst while mem_req high mid-wait -> mem_req, id_valid 0 and id_inst 0x13 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding word read
// at a time, and hands each instruction to ID over a valid/ready handshake.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  // state   | meaning
  // IDLE    | out of reset, first request issued on the next edge
  // FETCH   | request outstanding at mem_addr
  // DRAIN   | wrong-path request outstanding, redirect target held in pend_pc
  // HOLD    | instruction presented to ID, waiting for id_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  logic [1:0]  state;
  logic [31:0] pend_pc;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign mem_req  = (state == S_FETCH) || (state == S_DRAIN);
  assign id_valid = (state == S_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mem_addr <= RESET_ADDR;
      pend_pc  <= '0;
      id_pc    <= '0;
      id_inst  <= NOP_INST;
    end else begin
      case (state)
        S_IDLE: begin
          mem_addr <= RESET_ADDR;
          state    <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack) begin
            if (redirect_valid) begin
              mem_addr <= redir_pc;
            end else begin
              id_inst <= mem_rdata;
              id_pc   <= mem_addr;
              state   <= S_HOLD;
            end
          end else if (redirect_valid) begin
            // the issued request cannot be withdrawn; wait out its ack
            pend_pc <= redir_pc;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_ack) begin
            mem_addr <= redirect_valid ? redir_pc : pend_pc;
            state    <= S_FETCH;
          end else if (redirect_valid) begin
            pend_pc <= redir_pc;
          end
        end
        S_HOLD: begin
          // redirect outranks id_ready: a coincident handshake is not a transfer
          if (redirect_valid) begin
            mem_addr <= redir_pc;
            state    <= S_FETCH;
          end else if (id_ready) begin
            mem_addr <= id_pc + 32'd4;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
